// File: rtl/apb_ram_req_arbiter.sv
// Round-robin arbiter sharing one APB RAM slave between NUM_REQ requesters.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_ram_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       err_o,
  output logic                       timeout_o,
  output logic                       busy_o,
  output logic [ADDR_W-1:0]          paddr,
  output logic                       wr_en,
  output logic                       psel,
  output logic                       pen,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pselverr
);

  localparam int unsigned PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]       win;
  logic                win_vld;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_wr;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt;
  logic                wr_en_nxt, psel_nxt, pen_nxt;
  logic                tmo_hit;
  logic                acc_end;

  // First active request at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!win_vld && req[PW'(idx)]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // Field mux for the selected requester
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == win) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wr    = req_wr[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] tmo_cnt;

  // Counts ACCESS wait cycles; cleared while in SETUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign tmo_hit = (state == ACCESS) && !pready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign acc_end   = (state == ACCESS) && (pready || tmo_hit);
  assign done      = acc_end ? gnt : '0;
  assign rdata_o   = (acc_end && pready && !wr_en) ? prdata : '0;
  assign err_o     = acc_end && (pready ? pselverr : 1'b1);
  assign timeout_o = tmo_hit;
  assign busy_o    = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    gnt_nxt    = gnt;
    paddr_nxt  = paddr;
    wr_en_nxt  = wr_en;
    pwdata_nxt = pwdata;
    psel_nxt   = psel;
    pen_nxt    = pen;
    case (state)
      IDLE: begin
        if (win_vld) begin
          paddr_nxt  = sel_addr;
          wr_en_nxt  = sel_wr;
          pwdata_nxt = sel_wdata;
          psel_nxt   = 1'b1;
          pen_nxt    = 1'b0;
          gnt_nxt    = NUM_REQ'(1) << win;
          rr_ptr_nxt = PW'((32'(win) + 1) % NUM_REQ);
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        pen_nxt   = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (acc_end) begin
          psel_nxt  = 1'b0;
          pen_nxt   = 1'b0;
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      paddr  <= '0;
      wr_en  <= 1'b0;
      pwdata <= '0;
      psel   <= 1'b0;
      pen    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      gnt    <= gnt_nxt;
      paddr  <= paddr_nxt;
      wr_en  <= wr_en_nxt;
      pwdata <= pwdata_nxt;
      psel   <= psel_nxt;
      pen    <= pen_nxt;
    end
  end

endmodule

// File: tb/tb_apb_ram_req_arbiter.sv
// Bench for apb_ram_req_arbiter: directed plus randomized transfers against a
// round-robin / RAM reference model. Timeout steps need APB_TIMEOUT_EN.
module tb_apb_ram_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req, req_wr, gnt, done;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rdata_o, pwdata, prdata;
  logic              err_o, timeout_o, busy_o, wr_en, psel, pen, pready, pselverr;
  logic [AW-1:0]     paddr;

  int n_cmp = 0;
  int n_err = 0;
  int ptr   = 0;

  logic [DW-1:0] mem [256];
  logic [AW-1:0] f_addr  [N];
  logic          f_wr    [N];
  logic [DW-1:0] f_wdata [N];

  apb_ram_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata_o(rdata_o), .err_o(err_o),
    .timeout_o(timeout_o), .busy_o(busy_o), .paddr(paddr), .wr_en(wr_en), .psel(psel),
    .pen(pen), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pselverr(pselverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = f_addr[i];
      req_wr[i]             = f_wr[i];
      req_wdata[i*DW +: DW] = f_wdata[i];
    end
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      f_addr[i]  = AW'($urandom);
      f_wr[i]    = 1'($urandom);
      f_wdata[i] = $urandom;
    end
    drive_fields();
  endtask

  // Reference arbitration: lowest set index at or after the rotating pointer
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // One transfer: entered at posedge+1 with the FSM idle, leaves it the same way
  task automatic do_round(input logic [N-1:0] mask, input int waits, input logic serr);
    int            w;
    logic [AW-1:0] a;
    logic          wr;
    logic [DW-1:0] wd;
    w  = pick(mask);
    a  = f_addr[w];
    wr = f_wr[w];
    wd = f_wdata[w];
    req = mask;
    drive_fields();
    @(negedge clk);
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("idle_gnt", 64'(gnt), 64'(0));
    chk("idle_psel", 64'(psel), 64'(0));
    @(posedge clk); #1;
    randomize_fields();
    @(negedge clk);
    chk("setup_gnt", 64'(gnt), 64'(1) << w);
    chk("setup_psel", 64'(psel), 64'(1));
    chk("setup_pen", 64'(pen), 64'(0));
    chk("setup_paddr", 64'(paddr), 64'(a));
    chk("setup_wr_en", 64'(wr_en), 64'(wr));
    if (wr) chk("setup_pwdata", 64'(pwdata), 64'(wd));
    chk("setup_done", 64'(done), 64'(0));
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      pready   = (k == waits);
      prdata   = (pready && !wr) ? mem[a] : $urandom;
      pselverr = pready ? serr : 1'($urandom);
      @(negedge clk);
      chk("acc_psel", 64'(psel), 64'(1));
      chk("acc_pen", 64'(pen), 64'(1));
      chk("acc_paddr", 64'(paddr), 64'(a));
      chk("acc_gnt", 64'(gnt), 64'(1) << w);
      chk("acc_done", 64'(done), pready ? (64'(1) << w) : 64'(0));
      chk("acc_timeout", 64'(timeout_o), 64'(0));
      if (pready) begin
        chk("acc_err", 64'(err_o), 64'(serr));
        chk("acc_rdata", 64'(rdata_o), wr ? 64'(0) : 64'(mem[a]));
      end
    end
    @(posedge clk); #1;
    pready   = 1'b0;
    pselverr = 1'b0;
    req      = '0;
    if (wr) mem[a] = wd;
    ptr = (w + 1) % N;
  endtask

  initial begin
    int tw;
    rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pselverr = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    randomize_fields();
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_pen", 64'(pen), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // fairness: all four requesting, expected order 0,1,2,3,0
    for (int r = 0; r < 5; r++) begin
      randomize_fields();
      chk("rr_order", 64'(pick(4'b1111)), 64'(r % N));
      do_round(4'b1111, $urandom_range(0, 2), 1'b0);
    end

    // single write
    f_addr[0] = 8'h10; f_wr[0] = 1'b1; f_wdata[0] = 32'hDEADBEEF;
    do_round(4'b0001, 0, 1'b0);

    // read with three wait states
    mem[8'h20] = 32'hCAFEF00D;
    f_addr[2] = 8'h20; f_wr[2] = 1'b0;
    do_round(4'b0100, 3, 1'b0);

    // slave error, then a clean transfer
    f_addr[3] = 8'hFF; f_wr[3] = 1'b1; f_wdata[3] = $urandom;
    do_round(4'b1000, 0, 1'b1);
    randomize_fields();
    do_round(4'b1000, 1, 1'b0);

    // randomized traffic
    repeat (40) begin
      randomize_fields();
      do_round(N'($urandom_range(1, 15)), $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
    end

    // reset during a stalled ACCESS
    randomize_fields();
    req = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pready = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy_o), 64'(1));
    chk("mid_pen", 64'(pen), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_psel", 64'(psel), 64'(0));
    chk("mid_rst_pen", 64'(pen), 64'(0));
    chk("mid_rst_gnt", 64'(gnt), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; req = '0; ptr = 0;
    randomize_fields();
    do_round(4'b0010, 1, 1'b0);

`ifdef APB_TIMEOUT_EN
    // pready on the final allowed cycle completes normally
    randomize_fields();
    do_round(4'b0001, 15, 1'b0);
    // pready never arrives: forced completion on the 16th ACCESS cycle
    randomize_fields();
    req = 4'b1000;
    tw  = pick(4'b1000);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      pready   = 1'b0;
      pselverr = 1'($urandom);
      prdata   = $urandom;
      @(negedge clk);
      chk("tmo_done", 64'(done), (k == 15) ? (64'(1) << tw) : 64'(0));
      chk("tmo_flag", 64'(timeout_o), 64'(k == 15));
      if (k == 15) begin
        chk("tmo_err", 64'(err_o), 64'(1));
        chk("tmo_rdata", 64'(rdata_o), 64'(0));
      end
    end
    @(posedge clk); #1;
    req = '0;
    ptr = (tw + 1) % N;
    @(negedge clk);
    chk("tmo_idle", 64'(busy_o), 64'(0));
`else
    tw = 0;
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
